// File: rtl/pwm_servo_pkg.sv
// Shared servo PWM constants and the capture FSM state type.
// The servo generator uses the same mapping: pulse cycles = MIN_W + STEP * angle.
package pwm_servo_pkg;
    localparam int CLK_HZ     = 50_000_000;
    localparam int MIN_W      = 50000;
    localparam int STEP       = 275;
    localparam int MAX_ANGLE  = 180;
    localparam int GLITCH_W   = 500;
    localparam int ABORT_W    = 150000;
    localparam int LOSS_T     = 1250000;

    localparam int NUM_CH     = 4;
    localparam int WIDTH_BITS = 18;
    localparam int LOSS_BITS  = 21;
    localparam int ANGLE_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        DIVIDE,
        DONE
    } cap_state_t;
endpackage

// File: rtl/pwm_angle_if.sv
// PWM inputs and decoded angle outputs of the four-channel capture block.
// The master side drives the PWM lines; the slave side is the decoder.
interface pwm_angle_if;
    import pwm_servo_pkg::*;

    logic [NUM_CH-1:0]     pwm_in;
    logic [ANGLE_BITS-1:0] angle1;
    logic [ANGLE_BITS-1:0] angle2;
    logic [ANGLE_BITS-1:0] angle3;
    logic [ANGLE_BITS-1:0] angle4;
    logic [NUM_CH-1:0]     valid;
    logic [NUM_CH-1:0]     range_err;
    logic [NUM_CH-1:0]     loss;

    modport master (
        output pwm_in,
        input  angle1, angle2, angle3, angle4, valid, range_err, loss
    );

    modport slave (
        input  pwm_in,
        output angle1, angle2, angle3, angle4, valid, range_err, loss
    );
endinterface

// File: rtl/pwm_capture_channel.sv
// One servo PWM capture channel: synchroniser, edge detect, width FSM with a
// one-step-per-cycle divider, and a signal-loss watchdog.
module pwm_capture_channel import pwm_servo_pkg::*; #(
    parameter int MIN_W     = pwm_servo_pkg::MIN_W,
    parameter int STEP      = pwm_servo_pkg::STEP,
    parameter int MAX_ANGLE = pwm_servo_pkg::MAX_ANGLE,
    parameter int GLITCH_W  = pwm_servo_pkg::GLITCH_W,
    parameter int ABORT_W   = pwm_servo_pkg::ABORT_W,
    parameter int LOSS_T    = pwm_servo_pkg::LOSS_T
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  pwm_in,
    output logic [ANGLE_BITS-1:0] angle,
    output logic                  valid,
    output logic                  range_err,
    output logic                  loss
);
    localparam logic [WIDTH_BITS-1:0] MIN_V    = WIDTH_BITS'(MIN_W);
    localparam logic [WIDTH_BITS-1:0] STEP_V   = WIDTH_BITS'(STEP);
    localparam logic [WIDTH_BITS-1:0] GLITCH_V = WIDTH_BITS'(GLITCH_W);
    localparam logic [WIDTH_BITS-1:0] ABORT_V  = WIDTH_BITS'(ABORT_W);
    localparam logic [ANGLE_BITS-1:0] MAXA_V   = ANGLE_BITS'(MAX_ANGLE);
    localparam logic [LOSS_BITS-1:0]  LOSS_V   = LOSS_BITS'(LOSS_T);

    logic                  sync1_reg, sync2_reg, prev_reg;
    logic [1:0]            fill_reg;
    logic                  armed_reg;
    logic                  rise, fall;
    cap_state_t            state_reg;
    logic [WIDTH_BITS-1:0] width_reg, rem_reg;
    logic                  under_reg;
    logic [ANGLE_BITS-1:0] quot_reg, angle_reg;
    logic                  valid_reg, range_err_reg, loss_reg;
    logic [LOSS_BITS-1:0]  loss_cnt_reg;

    // Synchronise the input; arm edge detection only once a low level has been
    // seen after reset, so a pulse already high at reset release is skipped.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            fill_reg  <= 2'b00;
            armed_reg <= 1'b0;
        end else begin
            sync1_reg <= pwm_in;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            fill_reg  <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && !sync2_reg)
                armed_reg <= 1'b1;
        end
    end

    assign rise = armed_reg &&  sync2_reg && !prev_reg;
    assign fall = armed_reg && !sync2_reg &&  prev_reg;

    // Capture FSM: measure high time, divide by repeated subtraction, publish.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg     <= IDLE;
            width_reg     <= '0;
            rem_reg       <= '0;
            under_reg     <= 1'b0;
            quot_reg      <= '0;
            angle_reg     <= '0;
            valid_reg     <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        width_reg <= WIDTH_BITS'(1);
                        state_reg <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        if (width_reg < GLITCH_V) begin
                            state_reg <= IDLE;
                        end else begin
                            // Remainder wraps for short pulses; under_reg overrides it.
                            under_reg <= (width_reg < MIN_V);
                            rem_reg   <= width_reg - MIN_V;
                            quot_reg  <= '0;
                            state_reg <= DIVIDE;
                        end
                    end else if (width_reg >= ABORT_V) begin
                        range_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        width_reg <= width_reg + WIDTH_BITS'(1);
                    end
                end
                DIVIDE: begin
                    if (under_reg) begin
                        quot_reg      <= '0;
                        range_err_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else if (rem_reg >= STEP_V && quot_reg != MAXA_V) begin
                        rem_reg  <= rem_reg - STEP_V;
                        quot_reg <= quot_reg + ANGLE_BITS'(1);
                    end else begin
                        // A full step left over at the clamp means the pulse was too long.
                        range_err_reg <= (rem_reg >= STEP_V);
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    angle_reg <= quot_reg;
                    valid_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Loss watchdog: count cycles since the last rising edge, saturating;
    // the flag is sticky until this channel publishes a new angle.
    always_ff @(posedge clk) begin
        if (srst) begin
            loss_cnt_reg <= '0;
            loss_reg     <= 1'b0;
        end else begin
            if (rise)
                loss_cnt_reg <= '0;
            else if (loss_cnt_reg != LOSS_V)
                loss_cnt_reg <= loss_cnt_reg + LOSS_BITS'(1);

            if (state_reg == DONE)
                loss_reg <= 1'b0;
            else if (loss_cnt_reg == LOSS_V)
                loss_reg <= 1'b1;
        end
    end

    assign angle     = angle_reg;
    assign valid     = valid_reg;
    assign range_err = range_err_reg;
    assign loss      = loss_reg;
endmodule

// File: rtl/pwm_angle_decoder.sv
// Four-channel servo PWM angle decoder: one capture channel per input bit,
// outputs mapped onto the angle interface.
module pwm_angle_decoder import pwm_servo_pkg::*; #(
    parameter int MIN_W     = pwm_servo_pkg::MIN_W,
    parameter int STEP      = pwm_servo_pkg::STEP,
    parameter int MAX_ANGLE = pwm_servo_pkg::MAX_ANGLE,
    parameter int GLITCH_W  = pwm_servo_pkg::GLITCH_W,
    parameter int ABORT_W   = pwm_servo_pkg::ABORT_W,
    parameter int LOSS_T    = pwm_servo_pkg::LOSS_T
) (
    input  logic       clk,
    input  logic       rst,
    pwm_angle_if.slave bus
);
    logic [ANGLE_BITS-1:0] angle_ch [NUM_CH];
    logic [NUM_CH-1:0]     valid_ch;
    logic [NUM_CH-1:0]     err_ch;
    logic [NUM_CH-1:0]     loss_ch;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_capture_channel #(
                .MIN_W     (MIN_W),
                .STEP      (STEP),
                .MAX_ANGLE (MAX_ANGLE),
                .GLITCH_W  (GLITCH_W),
                .ABORT_W   (ABORT_W),
                .LOSS_T    (LOSS_T)
            ) u_ch (
                .clk       (clk),
                .srst      (rst),
                .pwm_in    (bus.pwm_in[gi]),
                .angle     (angle_ch[gi]),
                .valid     (valid_ch[gi]),
                .range_err (err_ch[gi]),
                .loss      (loss_ch[gi])
            );
        end
    endgenerate

    assign bus.angle1    = angle_ch[0];
    assign bus.angle2    = angle_ch[1];
    assign bus.angle3    = angle_ch[2];
    assign bus.angle4    = angle_ch[3];
    assign bus.valid     = valid_ch;
    assign bus.range_err = err_ch;
    assign bus.loss      = loss_ch;
endmodule

// File: tb/tb_pwm_angle_decoder.sv
// Bench for pwm_angle_decoder with time-scaled parameters (MIN_W 200, STEP 3,
// GLITCH_W 20, ABORT_W 1000, LOSS_T 3000) so every scenario fits a short run.
module tb_pwm_angle_decoder;
    localparam int T_MIN    = 200;
    localparam int T_STEP   = 3;
    localparam int T_MAX    = 180;
    localparam int T_GLITCH = 20;
    localparam int T_ABORT  = 1000;
    localparam int T_LOSS   = 3000;
    localparam int SETTLE   = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_angle_if bus ();

    pwm_angle_decoder #(
        .MIN_W(T_MIN), .STEP(T_STEP), .MAX_ANGLE(T_MAX),
        .GLITCH_W(T_GLITCH), .ABORT_W(T_ABORT), .LOSS_T(T_LOSS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         ch;
        logic [7:0] angle;
        logic       err;
        logic       loss;
        int         cyc;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         drop_cyc[4];
    int         rise_cyc[4];
    logic [7:0] m_angle[4];
    logic       m_err[4];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ang_of(input int ch);
        case (ch)
            0:       return bus.angle1;
            1:       return bus.angle2;
            2:       return bus.angle3;
            default: return bus.angle4;
        endcase
    endfunction

    // Record every valid strobe with the outputs seen alongside it.
    always @(negedge clk) begin
        ev_t e;
        for (int n = 0; n < 4; n++) begin
            if (bus.valid[n] === 1'b1) begin
                e.ch = n; e.angle = ang_of(n); e.err = bus.range_err[n];
                e.loss = bus.loss[n]; e.cyc = cyc;
                evq.push_back(e);
            end
        end
    end

    // Reference: angle = truncated (w-MIN)/STEP clamped at MAX; returns 1 if a valid is due.
    function automatic bit model_pulse(input int ch, input int w);
        if (w < T_GLITCH) return 1'b0;
        if (w < T_MIN) begin
            m_angle[ch] = 8'd0; m_err[ch] = 1'b1;
        end else if ((w - T_MIN) / T_STEP > T_MAX) begin
            m_angle[ch] = 8'(T_MAX); m_err[ch] = 1'b1;
        end else begin
            m_angle[ch] = 8'((w - T_MIN) / T_STEP); m_err[ch] = 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drive one pulse of w[n] cycles per channel (0 = none), starting off[n] cycles in.
    task automatic drive(input int w[4], input int off[4]);
        int len;
        len = 0;
        for (int n = 0; n < 4; n++)
            if (w[n] > 0 && off[n] + w[n] > len) len = off[n] + w[n];
        for (int c = 0; c <= len; c++) begin
            for (int n = 0; n < 4; n++) begin
                if (w[n] > 0 && c == off[n]) rise_cyc[n] = cyc;
                if (w[n] > 0 && c == off[n] + w[n]) drop_cyc[n] = cyc;
                bus.pwm_in[n] = (w[n] > 0 && c >= off[n] && c < off[n] + w[n]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pwm_in = 4'h0;
        idle(5);
        n_checks++; if ({bus.angle1, bus.angle2, bus.angle3, bus.angle4} !== 32'h0) $display("FAIL reset_angles: got %h want 0", {bus.angle1, bus.angle2, bus.angle3, bus.angle4}); else n_pass++;
        n_checks++; if (bus.valid !== 4'h0) $display("FAIL reset_valid: got %b want 0000", bus.valid); else n_pass++;
        n_checks++; if (bus.range_err !== 4'h0) $display("FAIL reset_err: got %b want 0000", bus.range_err); else n_pass++;
        n_checks++; if (bus.loss !== 4'h0) $display("FAIL reset_loss: got %b want 0000", bus.loss); else n_pass++;
        rst = 1'b0;
        idle(10);
        for (int n = 0; n < 4; n++) begin m_angle[n] = 8'd0; m_err[n] = 1'b0; end
    endtask

    task automatic test_single();
        int w[4]; int off[4];
        w = '{T_MIN, 0, 0, 0}; off = '{0, 0, 0, 0};
        evq.delete();
        drive(w, off); idle(SETTLE);
        void'(model_pulse(0, T_MIN));
        n_checks++; if (evq.size() != 1) $display("FAIL single_count: got %0d valids want 1", evq.size()); else n_pass++;
        if (evq.size() > 0) begin
            n_checks++; if (evq[0].ch != 0 || evq[0].angle !== 8'd0) $display("FAIL single_angle: got ch%0d angle %0d want ch0 angle 0", evq[0].ch, evq[0].angle); else n_pass++;
            n_checks++; if (evq[0].err !== 1'b0) $display("FAIL single_err: got %b want 0", evq[0].err); else n_pass++;
        end
    endtask

    task automatic test_latency();
        int w[4]; int off[4];
        w = '{0, 0, T_MIN + 90 * T_STEP, 0}; off = '{0, 0, 0, 0};
        evq.delete();
        drive(w, off); idle(SETTLE);
        void'(model_pulse(2, w[2]));
        n_checks++; if (evq.size() != 1) $display("FAIL latency_count: got %0d valids want 1", evq.size()); else n_pass++;
        if (evq.size() > 0) begin
            n_checks++; if (evq[0].angle !== 8'd90) $display("FAIL latency_angle: got %0d want 90", evq[0].angle); else n_pass++;
            // 3 cycles to the falling-edge detect, then q+2 = 92 cycles to valid.
            n_checks++; if (evq[0].cyc - drop_cyc[2] != 3 + 92) $display("FAIL latency_cycles: got %0d want %0d", evq[0].cyc - drop_cyc[2], 95); else n_pass++;
        end
        n_checks++; if (bus.angle3 !== 8'd90) $display("FAIL latency_hold: got %0d want 90", bus.angle3); else n_pass++;
    endtask

    task automatic test_simultaneous();
        int w[4]; int off[4];
        w = '{T_MIN, T_MIN + 90 * T_STEP, T_MIN + 180 * T_STEP, T_MIN + 2 * T_STEP - 1};
        off = '{0, 0, 0, 0};
        evq.delete();
        drive(w, off); idle(SETTLE);
        for (int n = 0; n < 4; n++) begin
            int cnt; ev_t e;
            cnt = 0;
            void'(model_pulse(n, w[n]));
            foreach (evq[i]) if (evq[i].ch == n) begin cnt++; e = evq[i]; end
            n_checks++; if (cnt != 1) $display("FAIL simul_count ch%0d: got %0d want 1", n, cnt); else n_pass++;
            if (cnt > 0) begin
                n_checks++; if (e.angle !== m_angle[n] || e.err !== 1'b0) $display("FAIL simul_angle ch%0d: got %0d/%b want %0d/0", n, e.angle, e.err, m_angle[n]); else n_pass++;
                n_checks++; if (e.cyc - drop_cyc[n] != 5 + int'(m_angle[n])) $display("FAIL simul_latency ch%0d: got %0d want %0d", n, e.cyc - drop_cyc[n], 5 + int'(m_angle[n])); else n_pass++;
            end
        end
    endtask

    task automatic test_range_glitch();
        int tbl[4]; int w[4]; int off[4];
        tbl = '{150, 10, 900, T_MIN + 90 * T_STEP};
        off = '{0, 0, 0, 0};
        for (int k = 0; k < 4; k++) begin
            bit due;
            w = '{0, 0, 0, tbl[k]};
            evq.delete();
            drive(w, off); idle(SETTLE);
            due = model_pulse(3, tbl[k]);
            n_checks++; if (evq.size() != (due ? 1 : 0)) $display("FAIL range_count w=%0d: got %0d valids want %0d", tbl[k], evq.size(), due ? 1 : 0); else n_pass++;
            n_checks++; if (bus.angle4 !== m_angle[3]) $display("FAIL range_angle w=%0d: got %0d want %0d", tbl[k], bus.angle4, m_angle[3]); else n_pass++;
            n_checks++; if (bus.range_err[3] !== m_err[3]) $display("FAIL range_err w=%0d: got %b want %b", tbl[k], bus.range_err[3], m_err[3]); else n_pass++;
        end
    endtask

    task automatic test_abort();
        int w[4]; int off[4];
        w = '{T_ABORT + 200, 0, 0, 0}; off = '{0, 0, 0, 0};
        evq.delete();
        drive(w, off); idle(SETTLE);
        m_err[0] = 1'b1;
        n_checks++; if (evq.size() != 0) $display("FAIL abort_valid: got %0d valids want 0", evq.size()); else n_pass++;
        n_checks++; if (bus.range_err[0] !== 1'b1) $display("FAIL abort_err: got %b want 1", bus.range_err[0]); else n_pass++;
        n_checks++; if (bus.angle1 !== m_angle[0]) $display("FAIL abort_angle: got %0d want %0d", bus.angle1, m_angle[0]); else n_pass++;
    endtask

    task automatic test_loss();
        int w[4]; int off[4];
        w = '{0, T_MIN + 90 * T_STEP, 0, 0}; off = '{0, 0, 0, 0};
        drive(w, off); idle(SETTLE);
        void'(model_pulse(1, w[1]));
        while (cyc < rise_cyc[1] + T_LOSS - 10) idle(1);
        n_checks++; if (bus.loss[1] !== 1'b0) $display("FAIL loss_early: got %b want 0", bus.loss[1]); else n_pass++;
        while (cyc < rise_cyc[1] + T_LOSS + 20) idle(1);
        n_checks++; if (bus.loss[1] !== 1'b1) $display("FAIL loss_set: got %b want 1", bus.loss[1]); else n_pass++;
        evq.delete();
        drive(w, off); idle(SETTLE);
        n_checks++; if (evq.size() != 1) $display("FAIL loss_count: got %0d valids want 1", evq.size()); else n_pass++;
        if (evq.size() > 0) begin
            n_checks++; if (evq[0].angle !== 8'd90 || evq[0].loss !== 1'b0) $display("FAIL loss_clear_at_valid: got angle %0d loss %b want 90/0", evq[0].angle, evq[0].loss); else n_pass++;
        end
        n_checks++; if (bus.loss[1] !== 1'b0 || bus.angle2 !== 8'd90) $display("FAIL loss_after: got loss %b angle %0d want 0/90", bus.loss[1], bus.angle2); else n_pass++;
    endtask

    task automatic test_reset_mid_pulse();
        int w[4]; int off[4];
        evq.delete();
        bus.pwm_in = 4'hF;
        idle(120);
        rst = 1'b1;
        idle(1);
        n_checks++; if ({bus.angle1, bus.angle2, bus.angle3, bus.angle4} !== 32'h0) $display("FAIL midrst_angles: got %h want 0", {bus.angle1, bus.angle2, bus.angle3, bus.angle4}); else n_pass++;
        n_checks++; if (bus.range_err !== 4'h0 || bus.loss !== 4'h0 || bus.valid !== 4'h0) $display("FAIL midrst_flags: got err %b loss %b valid %b want 0", bus.range_err, bus.loss, bus.valid); else n_pass++;
        rst = 1'b0;
        idle(300);
        bus.pwm_in = 4'h0;
        idle(SETTLE + 50);
        n_checks++; if (evq.size() != 0) $display("FAIL midrst_valid: got %0d valids want 0", evq.size()); else n_pass++;
        for (int n = 0; n < 4; n++) begin m_angle[n] = 8'd0; m_err[n] = 1'b0; end
        w = '{T_MIN + 90 * T_STEP, 0, 0, 0}; off = '{0, 0, 0, 0};
        drive(w, off); idle(SETTLE);
        void'(model_pulse(0, w[0]));
        n_checks++; if (evq.size() != 1 || bus.angle1 !== 8'd90 || bus.range_err[0] !== 1'b0) $display("FAIL midrst_next: got %0d valids angle %0d err %b want 1/90/0", evq.size(), bus.angle1, bus.range_err[0]); else n_pass++;
    endtask

    task automatic test_random();
        int w[4]; int off[4];
        for (int r = 0; r < 25; r++) begin
            bit due[4];
            for (int n = 0; n < 4; n++) begin
                int kind; int a;
                kind = $urandom_range(0, 9);
                if (kind == 0)      w[n] = $urandom_range(1, T_GLITCH - 1);
                else if (kind == 1) w[n] = $urandom_range(T_GLITCH, T_MIN - 1);
                else if (kind == 2) w[n] = $urandom_range(T_MIN + T_STEP * (T_MAX + 1), T_ABORT - 1);
                else begin
                    a = $urandom_range(0, T_MAX);
                    w[n] = T_MIN + T_STEP * a + ((a == T_MAX) ? 0 : $urandom_range(0, T_STEP - 1));
                end
                off[n] = $urandom_range(0, 20);
            end
            evq.delete();
            drive(w, off); idle(SETTLE);
            for (int n = 0; n < 4; n++) begin
                int cnt; ev_t e;
                cnt = 0;
                due[n] = model_pulse(n, w[n]);
                foreach (evq[i]) if (evq[i].ch == n) begin cnt++; e = evq[i]; end
                n_checks++; if (cnt != (due[n] ? 1 : 0)) $display("FAIL rand_count r%0d ch%0d w=%0d: got %0d want %0d", r, n, w[n], cnt, due[n] ? 1 : 0); else n_pass++;
                if (cnt == 1 && due[n]) begin
                    n_checks++; if (e.angle !== m_angle[n] || e.err !== m_err[n]) $display("FAIL rand_value r%0d ch%0d w=%0d: got %0d/%b want %0d/%b", r, n, w[n], e.angle, e.err, m_angle[n], m_err[n]); else n_pass++;
                    n_checks++; if (e.cyc - drop_cyc[n] != 5 + int'(m_angle[n]) || e.loss !== 1'b0) $display("FAIL rand_latency r%0d ch%0d: got %0d loss %b want %0d/0", r, n, e.cyc - drop_cyc[n], e.loss, 5 + int'(m_angle[n])); else n_pass++;
                end
                n_checks++; if (ang_of(n) !== m_angle[n] || bus.range_err[n] !== m_err[n]) $display("FAIL rand_state r%0d ch%0d: got %0d/%b want %0d/%b", r, n, ang_of(n), bus.range_err[n], m_angle[n], m_err[n]); else n_pass++;
            end
            $display("round %0d widths %0d %0d %0d %0d", r, w[0], w[1], w[2], w[3]);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pwm_in = 4'h0;
        idle(1);
        test_reset();
        test_single();
        test_latency();
        test_simultaneous();
        test_range_glitch();
        test_abort();
        test_loss();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end
endmodule
